// File: rtl/freq_step_sender.sv
// freq_step_sender: emits foas symmetric frequency-offset phase steps
// (k - foas/2) * step_inc as magnitude + sign beats over a valid/ready handshake.
// Optional feature macro: FREQ_STEP_SENDER_CONTINUOUS_EN -- repeat sweeps until reset.
module freq_step_sender #(
  parameter int phase_bits        = 10,
  parameter int foas              = 5,
  parameter int foas_counter_bits = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [phase_bits-1:0]        step_inc,
  output logic [phase_bits-1:0]        freq_step,
  output logic                         neg_shift,
  output logic                         freq_step_valid,
  input  logic                         freq_step_tready,
  output logic [foas_counter_bits-1:0] freq_step_index,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned                  CENTER    = foas / 2;
  localparam logic [foas_counter_bits-1:0] C_IDX     = foas_counter_bits'(CENTER);
  localparam logic [foas_counter_bits-1:0] LAST_IDX  = foas_counter_bits'(foas - 1);
  localparam logic                         NEG_FIRST = (CENTER != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [phase_bits-1:0]          step_q, step_d;
  logic [phase_bits-1:0]          acc_q, acc_d;
  logic [foas_counter_bits-1:0]   cnt_q, cnt_d;
  logic [phase_bits-1:0]          freq_q, freq_d;
  logic                           neg_q, neg_d;
  logic                           valid_q, valid_d;
  logic [foas_counter_bits-1:0]   idx_q, idx_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic [foas_counter_bits:0]     idx_inc;
`ifdef FREQ_STEP_SENDER_CONTINUOUS_EN
  logic [phase_bits-1:0]          start_mag_q, start_mag_d;
`endif

  assign idx_inc = {1'b0, idx_q} + 1'b1;

  // Next-state and registered-output computation for the sweep FSM.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    freq_d  = freq_q;
    neg_d   = neg_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef FREQ_STEP_SENDER_CONTINUOUS_EN
    start_mag_d = start_mag_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          step_d  = step_inc;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q == C_IDX) begin
          // accumulator now holds C*step_inc, the magnitude of offset 0
          freq_d  = acc_q;
          neg_d   = NEG_FIRST;
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = S_SEND;
`ifdef FREQ_STEP_SENDER_CONTINUOUS_EN
          start_mag_d = acc_q;
`endif
        end else begin
          acc_d = acc_q + step_q;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEND: begin
        if (valid_q && freq_step_tready) begin
          if (idx_q == LAST_IDX) begin
            done_d = 1'b1;
`ifdef FREQ_STEP_SENDER_CONTINUOUS_EN
            freq_d = start_mag_q;
            neg_d  = NEG_FIRST;
            idx_d  = '0;
`else
            valid_d = 1'b0;
            state_d = S_DONE;
`endif
          end else begin
            idx_d = idx_inc[foas_counter_bits-1:0];
            if (idx_q < C_IDX) begin
              freq_d = freq_q - step_q;
              neg_d  = (idx_inc < (foas_counter_bits + 1)'(CENTER));
            end else begin
              freq_d = freq_q + step_q;
              neg_d  = 1'b0;
            end
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      freq_q  <= '0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FREQ_STEP_SENDER_CONTINUOUS_EN
      start_mag_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      neg_q   <= neg_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FREQ_STEP_SENDER_CONTINUOUS_EN
      start_mag_q <= start_mag_d;
`endif
    end
  end

  assign freq_step       = freq_q;
  assign neg_shift       = neg_q;
  assign freq_step_valid = valid_q;
  assign freq_step_index = idx_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_freq_step_sender.sv
// Testbench for freq_step_sender (default build): directed literal sweeps plus
// randomized traffic compared every cycle against a behavioural model.
module tb_freq_step_sender;

  localparam int PB  = 10;
  localparam int N   = 5;
  localparam int FCB = 3;
  localparam int C   = N / 2;

  logic           clk = 1'b0;
  logic           reset, start, freq_step_tready;
  logic [PB-1:0]  step_inc, freq_step;
  logic           neg_shift, freq_step_valid, busy, done;
  logic [FCB-1:0] freq_step_index;

  logic           start1;
  logic [PB-1:0]  step1, freq1;
  logic           neg1, valid1, busy1, done1;
  logic [0:0]     idx1;

  always #5 clk = ~clk;

  freq_step_sender #(.phase_bits(PB), .foas(N), .foas_counter_bits(FCB)) u_dut (
    .clk(clk), .reset(reset), .start(start), .step_inc(step_inc),
    .freq_step(freq_step), .neg_shift(neg_shift), .freq_step_valid(freq_step_valid),
    .freq_step_tready(freq_step_tready), .freq_step_index(freq_step_index),
    .busy(busy), .done(done));

  freq_step_sender #(.phase_bits(PB), .foas(1), .foas_counter_bits(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .step_inc(step1),
    .freq_step(freq1), .neg_shift(neg1), .freq_step_valid(valid1),
    .freq_step_tready(1'b1), .freq_step_index(idx1),
    .busy(busy1), .done(done1));

  int passed = 0;
  int total  = 0;
  bit run_chk = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Offset k is (k-C)*step; the beat carries |k-C|*step reduced mod 2^PB.
  function automatic int mag(input int k, input int s);
    int d;
    d = k - C;
    if (d < 0) d = -d;
    return (d * s) % (1 << PB);
  endfunction

  // Behavioural model: 0 idle, 1 loading, 2 sending beat m_k, 3 done pulse.
  int m_st = 0, m_left = 0, m_k = 0, m_step = 0;
  bit m_done = 0;
  always @(posedge clk) begin
    m_done = 0;
    if (reset) m_st = 0;
    else case (m_st)
      0: if (start) begin m_step = int'(step_inc); m_left = C + 1; m_st = 1; end
      1: begin m_left--; if (m_left == 0) begin m_st = 2; m_k = 0; end end
      2: if (freq_step_tready) begin
           if (m_k == N - 1) begin m_st = 3; m_done = 1; end
           else m_k++;
         end
      default: m_st = 0;
    endcase
  end

  // Compare process: checks every cycle away from the active edge.
  always @(negedge clk) begin
    if (run_chk) begin
      chk("valid", int'(freq_step_valid), int'(m_st == 2));
      chk("busy",  int'(busy), int'(m_st != 0));
      chk("done",  int'(done), int'(m_done));
      if (m_st == 2) begin
        chk("freq_step", int'(freq_step), mag(m_k, m_step));
        chk("neg_shift", int'(neg_shift), int'(m_k < C));
        chk("index",     int'(freq_step_index), m_k);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int bf[N], bn[N], bi[N];

  task automatic do_sweep(input logic [PB-1:0] s, input bit disturb);
    int lc;
    step_inc = s; freq_step_tready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    lc = 1;
    while (!freq_step_valid && lc < 20) begin tick(); lc++; end
    chk("load_len", lc - 1, C + 1);
    for (int i = 0; i < N; i++) begin
      bf[i] = int'(freq_step); bn[i] = int'(neg_shift); bi[i] = int'(freq_step_index);
      if (disturb && i < N - 1) begin start = 1'b1; step_inc = 10'd99; end
      else start = 1'b0;
      tick();
    end
    start = 1'b0;
    chk("done_pulse", int'(done), 1);
    tick();
    chk("done_clear", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  task automatic cmp_beats(input string nm, input int ef[N], input int en[N]);
    for (int i = 0; i < N; i++) begin
      chk({nm, "_f"}, bf[i], ef[i]);
      chk({nm, "_n"}, bn[i], en[i]);
      chk({nm, "_i"}, bi[i], i);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; step_inc = '0; freq_step_tready = 1'b1;
    start1 = 1'b0; step1 = 10'd37;
    repeat (3) tick();
    chk("rst_freq", int'(freq_step), 0);
    chk("rst_neg", int'(neg_shift), 0);
    chk("rst_valid", int'(freq_step_valid), 0);
    chk("rst_index", int'(freq_step_index), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    run_chk = 1;
    tick();

    do_sweep(10'd10, 1'b0);
    cmp_beats("s10", '{20, 10, 0, 10, 20}, '{1, 1, 0, 0, 0});
    do_sweep(10'd600, 1'b0);
    cmp_beats("s600", '{176, 600, 0, 600, 176}, '{1, 1, 0, 0, 0});
    do_sweep(10'd10, 1'b1);
    cmp_beats("dist", '{20, 10, 0, 10, 20}, '{1, 1, 0, 0, 0});
    repeat (4) tick();
    chk("no_resweep", int'(busy), 0);

    // Backpressure at index 1 for four cycles.
    step_inc = 10'd10; start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!freq_step_valid && n < 20) begin tick(); n++; end
    tick();
    freq_step_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_f", int'(freq_step), 10);
      chk("stall_n", int'(neg_shift), 1);
      chk("stall_i", int'(freq_step_index), 1);
      chk("stall_v", int'(freq_step_valid), 1);
      tick();
    end
    freq_step_tready = 1'b1;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk("stall_end", int'(busy), 0);

    // Reset while beat 2 is pending.
    step_inc = 10'd10; start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(freq_step_valid && freq_step_index == 3'd2) && n < 20) begin tick(); n++; end
    chk("reach_idx2", int'(freq_step_index), 2);
    freq_step_tready = 1'b0; reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; freq_step_tready = 1'b1;
    chk("mr_freq", int'(freq_step), 0);
    chk("mr_neg", int'(neg_shift), 0);
    chk("mr_valid", int'(freq_step_valid), 0);
    chk("mr_index", int'(freq_step_index), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_done", int'(done), 0);
    tick();
    do_sweep(10'd7, 1'b0);
    cmp_beats("s7", '{14, 7, 0, 7, 14}, '{1, 1, 0, 0, 0});

    // Single-offset instance.
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("f1_load_busy", int'(busy1), 1);
    chk("f1_load_valid", int'(valid1), 0);
    tick();
    chk("f1_valid", int'(valid1), 1);
    chk("f1_freq", int'(freq1), 0);
    chk("f1_neg", int'(neg1), 0);
    chk("f1_idx", int'(idx1), 0);
    tick();
    chk("f1_done", int'(done1), 1);
    chk("f1_valid_off", int'(valid1), 0);
    tick();
    chk("f1_done_clr", int'(done1), 0);
    chk("f1_idle", int'(busy1), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom % 250) == 0;
      start            = ($urandom % 4) == 0;
      step_inc         = PB'($urandom);
      freq_step_tready = ($urandom % 3) != 0;
      tick();
    end
    reset = 1'b0; start = 1'b0;
    tick();
    run_chk = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/freq_step_sender.md
FREQ_STEP_SENDER -- requirements
Module: freq_step_sender

Interface
REQ-001 Parameter phase_bits, default 10: width of freq_step and step_inc.
REQ-002 Parameter foas, default 5: number of frequency offsets per sweep; SHALL be odd and at least 1.
REQ-003 Parameter foas_counter_bits, default 3: width of freq_step_index; SHALL satisfy 2^foas_counter_bits >= foas.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  sweep request; sampled only in IDLE.
REQ-007 step_inc  input  phase_bits  phase increment between adjacent offsets; latched on accepted start.
REQ-008 freq_step  output  phase_bits  magnitude of the current offset phase step.
REQ-009 neg_shift  output  1  1 = current offset is negative.
REQ-010 freq_step_valid  output  1  beat valid.
REQ-011 freq_step_tready  input  1  sink ready; a beat transfers when valid and ready are both 1.
REQ-012 freq_step_index  output  foas_counter_bits  index 0..foas-1 of the current beat.
REQ-013 busy  output  1  1 in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after the last beat transfers.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, SEND and DONE; all outputs SHALL be registered.
REQ-016 Let C = foas/2 (integer division). Offset k SHALL equal (k - C)*step_inc, computed modulo 2^phase_bits; freq_step = |offset|, neg_shift = (k < C).
REQ-017 IDLE: start=1 SHALL latch step_inc, clear the accumulator and load counter, and enter LOAD.
REQ-018 LOAD: each cycle, if load counter == C, enter SEND with freq_step = accumulator, neg_shift = (C != 0), freq_step_index = 0, valid = 1; otherwise accumulator += step_inc and counter++. LOAD SHALL last exactly C+1 cycles.
REQ-019 SEND: freq_step, neg_shift, freq_step_index and freq_step_valid SHALL hold stable while valid=1 and tready=0.
REQ-020 On a transfer with index < foas-1: index++; if index < C, freq_step -= step_inc and neg_shift = (index+1 < C); otherwise freq_step += step_inc and neg_shift = 0. valid stays 1 (back-to-back beats, one per cycle).
REQ-021 On a transfer with index == foas-1: valid <= 0 and the FSM enters DONE.
REQ-022 DONE: done = 1 for exactly one cycle, then IDLE.
REQ-023 start SHALL be ignored outside IDLE; step_inc changes after latching SHALL have no effect.
REQ-024 foas = 1: LOAD lasts 1 cycle; single beat (0, neg_shift 0, index 0).
REQ-025 Arithmetic SHALL wrap modulo 2^phase_bits with no saturation or overflow flag.

Reset
REQ-026 reset=1 SHALL force IDLE and drive freq_step=0, neg_shift=0, freq_step_valid=0, freq_step_index=0, busy=0 and done=0 on the next edge, from any state, including mid-SEND with a beat pending.
REQ-027 reset SHALL take priority over start and over any transfer in the same cycle.

Configuration
REQ-028 Macro FREQ_STEP_SENDER_CONTINUOUS_EN.
- Defined: a transfer at index foas-1 SHALL reload the start magnitude stored at the end of LOAD, set index 0 and neg_shift = (C != 0), and keep valid=1 and the FSM in SEND. done SHALL pulse for one cycle per completed sweep. Only reset exits the loop.
- Not defined: behaviour SHALL follow REQ-021/022 exactly, and the stored start-magnitude register SHALL NOT be present.

Verification
REQ-029 foas=5, step_inc=10, tready=1: start -> LOAD 3 cycles, then beats (freq_step,neg_shift,index) = (20,1,0),(10,1,1),(0,0,2),(10,0,3),(20,0,4) on consecutive cycles, then done pulse and busy=0.
REQ-030 Same setup, tready=0 for 4 cycles during index 1 -> (10,1,1) held stable with valid=1; sequence resumes unchanged after tready returns to 1.
REQ-031 phase_bits=10, foas=5, step_inc=600 -> beats (176,1),(600,1),(0,0),(600,0),(176,0).
REQ-032 start pulsed during SEND with step_inc changed to 99 -> sequence unaffected and no second sweep; foas=1 -> single beat (0,0,0).
REQ-033 reset asserted while valid=1 at index 2 -> next cycle all outputs 0 and IDLE; a new start then produces a full correct sweep.
REQ-034 With FREQ_STEP_SENDER_CONTINUOUS_EN, foas=3, step_inc=7 -> repeating (7,1,0),(0,0,1),(7,0,2) with one done pulse per sweep until reset.
